cell_sort_engine: RTL and testbench

- Parametrised frame-based insertion sorter built from a linear chain of `DEPTH` compare-and-shift cells.
- Accepts one `{key, metadata}` item per cycle over a valid/ready stream and keeps the best `DEPTH` items of a frame in sorted order.
- After the frame's last item, streams the sorted items out over a valid/ready master port.
- Sits between the upstream candidate builder and downstream consumers, as the top-K stage of the sort pipeline.

---
 rtl/cell_sort_pkg.sv | 41 ++++
 rtl/sort_cell.sv | 128 ++++++++++++
 rtl/cell_sort_engine.sv | 202 ++++++++++++++++++++
 tb/tb_cell_sort_engine.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/cell_sort_pkg.sv
// -----------------------------------------------------------------------------
// cell_sort_pkg
// Shared types and helpers for the cell_sort_engine top-K insertion sorter.
//   state_t : engine FSM states (LOAD collects a frame, DRAIN streams it out)
//   beats() : strict key comparison, direction selected by rev
//   cnt_w() : width of the item counter for a given chain depth
// -----------------------------------------------------------------------------
package cell_sort_pkg;

    // Keys are zero-extended to this width before comparison, so key widths
    // up to 64 bits are supported by the single shared compare helper.
    localparam int KEY_CMP_W = 64;

    typedef enum logic [0:0] {
        ST_LOAD  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    // True when key a strictly outranks key b: a > b for descending order,
    // a < b for ascending order. Equal keys never outrank, which is what
    // keeps insertion stable.
    function automatic logic beats(
        input logic [KEY_CMP_W-1:0] a,
        input logic [KEY_CMP_W-1:0] b,
        input logic                 rev
    );
        logic r;
        if (rev) begin
            r = (a < b);
        end else begin
            r = (a > b);
        end
        return r;
    endfunction

    // Counter width able to hold the values 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sort_cell.sv
// -----------------------------------------------------------------------------
// sort_cell
// One compare-and-shift storage cell of the insertion chain. Holds
// {valid, key, meta}. An empty cell always wins the comparison.
//
// Optional feature: define CELL_SORT_METADATA_EN to build the metadata
// register; otherwise meta reads as zero and the metadata inputs are ignored.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset (cell empties)
//   in_key, in_meta       item broadcast to every cell during insertion
//   prev_valid/key/meta   contents of the predecessor cell (toward cell 0)
//   prev_won              predecessor's win flag for the broadcast item
//   next_valid/key/meta   contents of the successor cell (away from cell 0)
//   load_en               an item is being inserted this cycle
//   shift_en              the chain drains one item toward cell 0 this cycle
//   valid, key, meta      own contents
//   won                   broadcast item outranks this cell (or cell empty)
// -----------------------------------------------------------------------------
module sort_cell
    import cell_sort_pkg::*;
#(
    parameter int SORTB = 8,
    parameter int METAB = 32,
    parameter int REV   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SORTB-1:0] in_key,
    input  logic [METAB-1:0] in_meta,
    input  logic             prev_valid,
    input  logic [SORTB-1:0] prev_key,
    input  logic [METAB-1:0] prev_meta,
    input  logic             prev_won,
    input  logic             next_valid,
    input  logic [SORTB-1:0] next_key,
    input  logic [METAB-1:0] next_meta,
    input  logic             load_en,
    input  logic             shift_en,
    output logic             valid,
    output logic [SORTB-1:0] key,
    output logic [METAB-1:0] meta,
    output logic             won
);

    logic             valid_q, valid_d;
    logic [SORTB-1:0] key_q,   key_d;

    assign won   = !valid_q || beats(KEY_CMP_W'(in_key), KEY_CMP_W'(key_q), (REV != 0));
    assign valid = valid_q;
    assign key   = key_q;

    // Next contents: take the predecessor when an earlier cell claimed the
    // item (the chain ripples down), take the item when this is the first
    // winner, or pull the successor in when draining.
    always_comb begin
        valid_d = valid_q;
        key_d   = key_q;
        if (load_en) begin
            if (prev_won) begin
                valid_d = prev_valid;
                key_d   = prev_key;
            end else if (won) begin
                valid_d = 1'b1;
                key_d   = in_key;
            end else begin
                valid_d = valid_q;
                key_d   = key_q;
            end
        end else if (shift_en) begin
            valid_d = next_valid;
            key_d   = next_key;
        end else begin
            valid_d = valid_q;
            key_d   = key_q;
        end
    end

    // Cell valid/key registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            key_q   <= {SORTB{1'b0}};
        end else begin
            valid_q <= valid_d;
            key_q   <= key_d;
        end
    end

`ifdef CELL_SORT_METADATA_EN
    logic [METAB-1:0] meta_q, meta_d;

    assign meta = meta_q;

    // Metadata follows exactly the same selection as the key.
    always_comb begin
        meta_d = meta_q;
        if (load_en) begin
            if (prev_won) begin
                meta_d = prev_meta;
            end else if (won) begin
                meta_d = in_meta;
            end else begin
                meta_d = meta_q;
            end
        end else if (shift_en) begin
            meta_d = next_meta;
        end else begin
            meta_d = meta_q;
        end
    end

    // Cell metadata register.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= {METAB{1'b0}};
        end else begin
            meta_q <= meta_d;
        end
    end
`else
    logic meta_unused_s;

    assign meta          = {METAB{1'b0}};
    assign meta_unused_s = ^{in_meta, prev_meta, next_meta};
`endif

endmodule

// File: rtl/cell_sort_engine.sv
// -----------------------------------------------------------------------------
// cell_sort_engine
// Frame-based top-K insertion sorter. Items arrive one per cycle on the
// s_* stream and are inserted into a chain of DEPTH sort_cell instances that
// stays ordered (descending for REV=0, ascending for REV=1, ties stable).
// When the frame's last item is accepted the engine drains the chain in
// order on the m_* stream, then returns to collecting the next frame.
//
// Optional feature: define CELL_SORT_METADATA_EN to carry s_meta with each
// key; otherwise s_meta is ignored and m_meta is always zero.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   s_data, s_meta           input key / metadata
//   s_valid, s_last, s_ready input handshake; s_last closes the frame
//   m_data, m_meta           output key / metadata (cell 0 contents)
//   m_valid, m_last, m_ready output handshake; m_last marks the final item
//   count                    items currently held (saturates at DEPTH)
//   overflow                 sticky: at least one item dropped this frame
// -----------------------------------------------------------------------------
module cell_sort_engine
    import cell_sort_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int SORTB = 8,
    parameter int METAB = 32,
    parameter int REV   = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [SORTB-1:0]          s_data,
    input  logic [METAB-1:0]          s_meta,
    input  logic                      s_valid,
    input  logic                      s_last,
    output logic                      s_ready,
    output logic [SORTB-1:0]          m_data,
    output logic [METAB-1:0]          m_meta,
    output logic                      m_valid,
    output logic                      m_last,
    input  logic                      m_ready,
    output logic [cnt_w(DEPTH)-1:0]   count,
    output logic                      overflow
);

    localparam int CNTW = cnt_w(DEPTH);
    localparam logic [CNTW-1:0] CNT_ZERO = {CNTW{1'b0}};
    localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1'b1);
    localparam logic [CNTW-1:0] CNT_FULL = CNTW'(DEPTH);

    state_t          state_q, state_d;
    logic [CNTW-1:0] count_q, count_d;
    logic            overflow_q, overflow_d;
    logic            s_ready_q, s_ready_d;

    logic             cell_valid_s [DEPTH];
    logic [SORTB-1:0] cell_key_s   [DEPTH];
    logic [METAB-1:0] cell_meta_s  [DEPTH];
    logic             cell_won_s   [DEPTH];

    logic ins_s;
    logic pop_s;
    logic drain_s;
    logic won_unused_s;

    assign drain_s = (state_q == ST_DRAIN);
    assign ins_s   = s_ready_q & s_valid;
    assign pop_s   = drain_s & cell_valid_s[0] & m_ready;

    // The last cell's win flag has no successor to feed.
    assign won_unused_s = cell_won_s[DEPTH-1];

    for (genvar i = 0; i < DEPTH; i++) begin : g_cell
        logic             prev_valid_s;
        logic [SORTB-1:0] prev_key_s;
        logic [METAB-1:0] prev_meta_s;
        logic             prev_won_s;
        logic             next_valid_s;
        logic [SORTB-1:0] next_key_s;
        logic [METAB-1:0] next_meta_s;

        // Cell 0 has no predecessor: it never inherits a shifted item.
        if (i == 0) begin : g_head
            assign prev_valid_s = 1'b0;
            assign prev_key_s   = {SORTB{1'b0}};
            assign prev_meta_s  = {METAB{1'b0}};
            assign prev_won_s   = 1'b0;
        end else begin : g_body
            assign prev_valid_s = cell_valid_s[i-1];
            assign prev_key_s   = cell_key_s[i-1];
            assign prev_meta_s  = cell_meta_s[i-1];
            assign prev_won_s   = cell_won_s[i-1];
        end

        // The last cell pulls in an empty slot while draining.
        if (i == DEPTH - 1) begin : g_tail
            assign next_valid_s = 1'b0;
            assign next_key_s   = {SORTB{1'b0}};
            assign next_meta_s  = {METAB{1'b0}};
        end else begin : g_link
            assign next_valid_s = cell_valid_s[i+1];
            assign next_key_s   = cell_key_s[i+1];
            assign next_meta_s  = cell_meta_s[i+1];
        end

        sort_cell #(
            .SORTB (SORTB),
            .METAB (METAB),
            .REV   (REV)
        ) u_cell (
            .clk        (clk),
            .rst        (rst),
            .in_key     (s_data),
            .in_meta    (s_meta),
            .prev_valid (prev_valid_s),
            .prev_key   (prev_key_s),
            .prev_meta  (prev_meta_s),
            .prev_won   (prev_won_s),
            .next_valid (next_valid_s),
            .next_key   (next_key_s),
            .next_meta  (next_meta_s),
            .load_en    (ins_s),
            .shift_en   (pop_s),
            .valid      (cell_valid_s[i]),
            .key        (cell_key_s[i]),
            .meta       (cell_meta_s[i]),
            .won        (cell_won_s[i])
        );
    end

    // FSM next state, item count and sticky overflow.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        case (state_q)
            ST_LOAD: begin
                if (ins_s) begin
                    // count==0 in LOAD means this is the frame's first item,
                    // which is where the previous frame's overflow is cleared.
                    overflow_d = (count_q == CNT_FULL) |
                                 ((count_q != CNT_ZERO) & overflow_q);
                    if (count_q != CNT_FULL) begin
                        count_d = count_q + CNT_ONE;
                    end else begin
                        count_d = count_q;
                    end
                    if (s_last) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_DRAIN: begin
                if (pop_s) begin
                    count_d = count_q - CNT_ONE;
                    if (count_q == CNT_ONE) begin
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d    = ST_LOAD;
                count_d    = CNT_ZERO;
                overflow_d = 1'b0;
            end
        endcase
        // s_ready is a registered decode of the next state.
        s_ready_d = (state_d == ST_LOAD);
    end

    // Control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_LOAD;
            count_q    <= CNT_ZERO;
            overflow_q <= 1'b0;
            s_ready_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            s_ready_q  <= s_ready_d;
        end
    end

    // Output side is cell 0 of the chain, qualified by DRAIN.
    assign s_ready  = s_ready_q;
    assign m_valid  = drain_s & cell_valid_s[0];
    assign m_last   = drain_s & cell_valid_s[0] & (count_q == CNT_ONE);
    assign m_data   = cell_key_s[0];
    assign m_meta   = cell_meta_s[0];
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_cell_sort_engine.sv
module tb_cell_sort_engine;

    localparam int DEPTH = 4;
    localparam int SORTB = 8;
    localparam int METAB = 32;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int MAXF  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [SORTB-1:0] s_data;
    logic [METAB-1:0] s_meta;
    logic             s_valid;
    logic             s_last;
    logic             m_ready;

    // Descending instance (d_*) and ascending instance (a_*), same stimulus.
    logic             d_s_ready, d_m_valid, d_m_last, d_overflow;
    logic [SORTB-1:0] d_m_data;
    logic [METAB-1:0] d_m_meta;
    logic [CW-1:0]    d_count;
    logic             a_s_ready, a_m_valid, a_m_last, a_overflow;
    logic [SORTB-1:0] a_m_data;
    logic [METAB-1:0] a_m_meta;
    logic [CW-1:0]    a_count;

    cell_sort_engine #(.DEPTH(DEPTH), .SORTB(SORTB), .METAB(METAB), .REV(0)) dut_d (
        .clk(clk), .rst(rst), .s_data(s_data), .s_meta(s_meta), .s_valid(s_valid),
        .s_last(s_last), .s_ready(d_s_ready), .m_data(d_m_data), .m_meta(d_m_meta),
        .m_valid(d_m_valid), .m_last(d_m_last), .m_ready(m_ready), .count(d_count),
        .overflow(d_overflow)
    );

    cell_sort_engine #(.DEPTH(DEPTH), .SORTB(SORTB), .METAB(METAB), .REV(1)) dut_a (
        .clk(clk), .rst(rst), .s_data(s_data), .s_meta(s_meta), .s_valid(s_valid),
        .s_last(s_last), .s_ready(a_s_ready), .m_data(a_m_data), .m_meta(a_m_meta),
        .m_valid(a_m_valid), .m_last(a_m_last), .m_ready(m_ready), .count(a_count),
        .overflow(a_overflow)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Current frame (arrival order) and expected output per direction.
    int               fn;
    logic [SORTB-1:0] fk [MAXF];
    logic [METAB-1:0] fm [MAXF];
    logic [SORTB-1:0] ek [2][DEPTH];
    logic [METAB-1:0] em [2][DEPTH];
    int               ekn;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [METAB-1:0] meta_exp(input logic [METAB-1:0] m);
`ifdef CELL_SORT_METADATA_EN
        return m;
`else
        return {METAB{1'b0}} & m;
`endif
    endfunction

    // Reference: stable sort of the frame, keep the best DEPTH entries.
    // Repeated selection of the best unused item; ties go to the earliest.
    task automatic build_expected();
        ekn = (fn < DEPTH) ? fn : DEPTH;
        for (int r = 0; r < 2; r++) begin
            bit used [MAXF];
            for (int i = 0; i < MAXF; i++) used[i] = 1'b0;
            for (int j = 0; j < ekn; j++) begin
                int best;
                best = -1;
                for (int i = 0; i < fn; i++) begin
                    if (!used[i]) begin
                        if (best < 0) best = i;
                        else if (r == 0 && fk[i] > fk[best]) best = i;
                        else if (r == 1 && fk[i] < fk[best]) best = i;
                    end
                end
                used[best] = 1'b1;
                ek[r][j] = fk[best];
                em[r][j] = meta_exp(fm[best]);
            end
        end
    endtask

    // Sends the frame, then drains up to max_pops items.
    // bp_mode 0: m_ready always 1; 1: random; 2: low 3 cycles after 1st beat.
    task automatic run_frame(input int bp_mode, input int max_pops);
        int j, cyc, hold;
        logic rdy;
        build_expected();
        for (int i = 0; i < fn; i++) begin
            s_valid = 1'b1;
            s_data  = fk[i];
            s_meta  = fm[i];
            s_last  = (i == fn - 1);
            chk("s_ready_desc", d_s_ready, 1'b1);
            chk("s_ready_asc", a_s_ready, 1'b1);
            @(negedge clk);
            chk("count_load_desc", d_count, (i + 1 < DEPTH) ? i + 1 : DEPTH);
            chk("count_load_asc", a_count, (i + 1 < DEPTH) ? i + 1 : DEPTH);
            chk("overflow_load", d_overflow, (i + 1 > DEPTH));
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        j = 0; cyc = 0; hold = 0;
        while (j < ekn && j < max_pops && cyc < 200) begin
            if (bp_mode == 1) rdy = ($urandom_range(0, 2) != 0);
            else if (bp_mode == 2 && j == 1 && hold < 3) begin rdy = 1'b0; hold++; end
            else rdy = 1'b1;
            m_ready = rdy;
            chk("m_valid_desc", d_m_valid, 1'b1);
            chk("m_valid_asc", a_m_valid, 1'b1);
            chk("m_data_desc", d_m_data, ek[0][j]);
            chk("m_data_asc", a_m_data, ek[1][j]);
            chk("m_meta_desc", d_m_meta, em[0][j]);
            chk("m_meta_asc", a_m_meta, em[1][j]);
            chk("m_last_desc", d_m_last, (j == ekn - 1));
            chk("m_last_asc", a_m_last, (j == ekn - 1));
            chk("count_drain", d_count, ekn - j);
            chk("overflow_drain_desc", d_overflow, (fn > DEPTH));
            chk("overflow_drain_asc", a_overflow, (fn > DEPTH));
            chk("s_ready_drain", d_s_ready, 1'b0);
            @(negedge clk);
            if (rdy) j++;
            cyc++;
        end
        m_ready = 1'b0;
        chk("drain_bound", (cyc < 200), 1'b1);
        if (j == ekn) begin
            chk("m_valid_after_desc", d_m_valid, 1'b0);
            chk("m_valid_after_asc", a_m_valid, 1'b0);
            chk("count_after", d_count, 0);
            chk("s_ready_after_desc", d_s_ready, 1'b1);
            chk("s_ready_after_asc", a_s_ready, 1'b1);
            chk("overflow_sticky", d_overflow, (fn > DEPTH));
        end
    endtask

    initial begin
        s_data  = '0;
        s_meta  = '0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        m_ready = 1'b0;
        rst     = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state.
        chk("rst_s_ready", d_s_ready, 1'b0);
        chk("rst_m_valid", d_m_valid, 1'b0);
        chk("rst_m_last", d_m_last, 1'b0);
        chk("rst_m_data", d_m_data, 0);
        chk("rst_m_meta", d_m_meta, 0);
        chk("rst_count", d_count, 0);
        chk("rst_overflow", d_overflow, 1'b0);
        chk("rst_s_ready_asc", a_s_ready, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Basic sort 3,7,5.
        fn = 3; fk[0] = 8'd3; fk[1] = 8'd7; fk[2] = 8'd5;
        fm[0] = 32'h11; fm[1] = 32'h22; fm[2] = 32'h33;
        run_frame(0, 99);

        // Overflow 1,9,4,6,2,8.
        fn = 6;
        fk[0] = 8'd1; fk[1] = 8'd9; fk[2] = 8'd4; fk[3] = 8'd6; fk[4] = 8'd2; fk[5] = 8'd8;
        for (int i = 0; i < 6; i++) fm[i] = 32'h100 + i;
        run_frame(0, 99);

        // Stable ties (5,A),(5,B),(2,C); also clears the previous overflow.
        fn = 3; fk[0] = 8'd5; fk[1] = 8'd5; fk[2] = 8'd2;
        fm[0] = 32'hA; fm[1] = 32'hB; fm[2] = 32'hC;
        run_frame(0, 99);

        // Backpressure 7,5,3.
        fn = 3; fk[0] = 8'd7; fk[1] = 8'd5; fk[2] = 8'd3;
        fm[0] = 32'h7; fm[1] = 32'h5; fm[2] = 32'h3;
        run_frame(2, 99);

        // Reset after one of three drain beats.
        fn = 3; fk[0] = 8'd3; fk[1] = 8'd7; fk[2] = 8'd5;
        fm[0] = 32'h1; fm[1] = 32'h2; fm[2] = 32'h3;
        run_frame(0, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_m_valid_desc", d_m_valid, 1'b0);
        chk("midrst_m_valid_asc", a_m_valid, 1'b0);
        chk("midrst_count", d_count, 0);
        chk("midrst_s_ready", d_s_ready, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk("postrst_s_ready", d_s_ready, 1'b1);
        fn = 1; fk[0] = 8'd2; fm[0] = 32'hD;
        run_frame(0, 99);

        // Randomized frames, random backpressure.
        for (int f = 0; f < 30; f++) begin
            fn = $urandom_range(1, 9);
            for (int i = 0; i < fn; i++) begin
                fk[i] = (f % 2 == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(0, 255));
                fm[i] = $urandom;
            end
            run_frame(1, 99);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
